// File: rtl/call_ret_seq_pkg.sv
// -----------------------------------------------------------------------------
// call_ret_seq_pkg
//   Shared types for the CALL/RET sequencer of the RISC-Mini core.
//   - seq_state_e : FSM state encoding (also visible on the state_dbg port)
//   - fault_e     : fault codes reported on the fault port
// -----------------------------------------------------------------------------
package call_ret_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH     = 3'd1,
    ST_POP_REQ  = 3'd2,
    ST_POP_WAIT = 3'd3,
    ST_REDIRECT = 3'd4,
    ST_FAULT    = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    FLT_NONE = 2'd0,
    FLT_OVF  = 2'd1,
    FLT_UNF  = 2'd2,
    FLT_ILL  = 2'd3
  } fault_e;

endpackage : call_ret_seq_pkg

// File: rtl/call_ret_seq.sv
// -----------------------------------------------------------------------------
// call_ret_seq
//   Multi-cycle sequencer for CALL and RET. Holds the core stalled while the
//   return address is pushed to / popped from a descending stack in dmem,
//   owns the stack pointer, then redirects the PC with a one-cycle strobe.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   start_call          decoder strobe for a valid CALL (samples pc_plus4/target)
//   start_ret           decoder strobe for a valid RET
//   pc_plus4, target    return address and call target
//   mem_req/we/addr/wdata  shared dmem request port (push = write, pop = read)
//   mem_gnt             request accepted this cycle
//   mem_rdata/rvalid    pop read data, at least one cycle after the grant
//   stall               freeze fetch/decode (combinational on the strobes)
//   pc_load, pc_next    one-cycle PC redirect strobe and target
//   sp                  stack pointer, points at the next free slot
//   fault, fault_clr    sticky fault code and its clear
//   state_dbg           current FSM state, for debug and checker binding
//
// dmem handshake: a request is held with mem_req/mem_we/mem_addr/mem_wdata
// stable until the cycle mem_gnt is high; that cycle completes the transfer.
// For a read, mem_rvalid is only honoured in ST_POP_WAIT and ignored elsewhere.
// -----------------------------------------------------------------------------
module call_ret_seq
  import call_ret_seq_pkg::*;
#(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned AWIDTH      = 16,
  parameter int unsigned STACK_BASE  = 16'h00FF,
  parameter int unsigned STACK_LIMIT = 16'h00FC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_call,
  input  logic              start_ret,
  input  logic [DWIDTH-1:0] pc_plus4,
  input  logic [DWIDTH-1:0] target,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              stall,
  output logic              pc_load,
  output logic [DWIDTH-1:0] pc_next,
  output logic [AWIDTH-1:0] sp,
  output logic [1:0]        fault,
  input  logic              fault_clr,
  output logic [2:0]        state_dbg
);

  // Empty: sp at the top slot. Full: sp one below the lowest usable slot.
  localparam logic [AWIDTH-1:0] SP_EMPTY = AWIDTH'(STACK_BASE);
  localparam logic [AWIDTH-1:0] SP_FULL  = AWIDTH'(STACK_LIMIT - 1);
  localparam logic [AWIDTH-1:0] SP_ONE   = AWIDTH'(1);

  seq_state_e        state;
  fault_e            fault_q;
  logic [AWIDTH-1:0] sp_q;
  logic [DWIDTH-1:0] pc_next_q;
  logic [DWIDTH-1:0] ret_addr_q;
  logic [DWIDTH-1:0] target_q;

  // ---------------------------------------------------------------------------
  // Sequencer FSM, stack pointer and latches
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      fault_q    <= FLT_NONE;
      sp_q       <= SP_EMPTY;
      pc_next_q  <= '0;
      ret_addr_q <= '0;
      target_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_call && start_ret) begin
            fault_q <= FLT_ILL;
            state   <= ST_FAULT;
          end else if (start_call) begin
            if (sp_q == SP_FULL) begin
              fault_q <= FLT_OVF;
              state   <= ST_FAULT;
            end else begin
              ret_addr_q <= pc_plus4;
              target_q   <= target;
              state      <= ST_PUSH;
            end
          end else if (start_ret) begin
            if (sp_q == SP_EMPTY) begin
              fault_q <= FLT_UNF;
              state   <= ST_FAULT;
            end else begin
              state <= ST_POP_REQ;
            end
          end
        end

        ST_PUSH: begin
          if (mem_gnt) begin
            sp_q      <= sp_q - SP_ONE;
            pc_next_q <= target_q;
            state     <= ST_REDIRECT;
          end
        end

        ST_POP_REQ: begin
          if (mem_gnt) begin
            sp_q  <= sp_q + SP_ONE;
            state <= ST_POP_WAIT;
          end
        end

        ST_POP_WAIT: begin
          if (mem_rvalid) begin
            pc_next_q <= mem_rdata;
            state     <= ST_REDIRECT;
          end
        end

        ST_REDIRECT: begin
          state <= ST_IDLE;
        end

        ST_FAULT: begin
          if (fault_clr) begin
            fault_q <= FLT_NONE;
            state   <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from the state register. Because state is cleared by the
  // asynchronous reset, mem_req drops as soon as rst rises.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = sp_q;
    mem_wdata = '0;
    case (state)
      ST_PUSH: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = ret_addr_q;
      end
      ST_POP_REQ: begin
        mem_req  = 1'b1;
        mem_addr = sp_q + SP_ONE;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // Stall reacts to the strobes in the same cycle so the decoder never sees a
  // second instruction; it is held low while reset is asserted.
  assign stall     = !rst && ((state != ST_IDLE) || start_call || start_ret);
  assign pc_load   = (state == ST_REDIRECT);
  assign pc_next   = pc_next_q;
  assign sp        = sp_q;
  assign fault     = fault_q;
  assign state_dbg = state;

endmodule : call_ret_seq

// File: tb/tb_call_ret_seq.sv
// -----------------------------------------------------------------------------
// tb_call_ret_seq
//   Directed bench for call_ret_seq. Inputs change 1 time unit after the
//   rising edge; outputs are sampled 1 unit later, away from the clock edge.
// -----------------------------------------------------------------------------
module tb_call_ret_seq;

  logic        clk;
  logic        rst;
  logic        start_call;
  logic        start_ret;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        stall;
  logic        pc_load;
  logic [31:0] pc_next;
  logic [15:0] sp;
  logic [1:0]  fault;
  logic        fault_clr;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  call_ret_seq #(
    .DWIDTH(32), .AWIDTH(16), .STACK_BASE(16'h00FF), .STACK_LIMIT(16'h00FC)
  ) dut (
    .clk(clk), .rst(rst), .start_call(start_call), .start_ret(start_ret),
    .pc_plus4(pc_plus4), .target(target), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .stall(stall),
    .pc_load(pc_load), .pc_next(pc_next), .sp(sp), .fault(fault),
    .fault_clr(fault_clr), .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start_call = 0; start_ret = 0; fault_clr = 0; mem_rvalid = 0; mem_gnt = 1;
    rst = 1;
    #3;
    rst = 0;
    step();
  endtask

  // Complete CALL with immediate grant; returns one cycle into IDLE.
  task automatic do_call(input logic [31:0] ra, input logic [31:0] tg);
    mem_gnt = 1; pc_plus4 = ra; target = tg; start_call = 1;
    step();
    start_call = 0;
    step();
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1; start_call = 0; start_ret = 0; fault_clr = 0;
    pc_plus4 = 0; target = 0; mem_gnt = 0; mem_rdata = 0; mem_rvalid = 0;
    #3;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0h exp 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %0h exp 0", mem_we); end
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL rst_pc_load got %0h exp 0", pc_load); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h exp 0", stall); end
    checks++; if (sp !== 16'h00FF) begin errors++; $display("FAIL rst_sp got %h exp 00ff", sp); end
    checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL rst_pc_next got %h exp 0", pc_next); end
    checks++; if (fault !== 2'd0) begin errors++; $display("FAIL rst_fault got %0d exp 0", fault); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_dbg); end
    rst = 0;
    step();
  endtask

  task automatic test_call();
    mem_gnt = 1; pc_plus4 = 32'h104; target = 32'h200; start_call = 1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL call_strobe_stall got %0h exp 1", stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL call_strobe_req got %0h exp 0", mem_req); end
    step();
    start_call = 0;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL call_push_req got req %0h we %0h exp 1 1", mem_req, mem_we); end
    checks++; if (mem_addr !== 16'h00FF) begin errors++; $display("FAIL call_push_addr got %h exp 00ff", mem_addr); end
    checks++; if (mem_wdata !== 32'h104) begin errors++; $display("FAIL call_push_wdata got %h exp 104", mem_wdata); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL call_push_stall got %0h exp 1", stall); end
    step();
    checks++; if (pc_load !== 1'b1) begin errors++; $display("FAIL call_pc_load got %0h exp 1", pc_load); end
    checks++; if (pc_next !== 32'h200) begin errors++; $display("FAIL call_pc_next got %h exp 200", pc_next); end
    checks++; if (sp !== 16'h00FE) begin errors++; $display("FAIL call_sp got %h exp 00fe", sp); end
    checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL call_redirect got stall %0h req %0h exp 1 0", stall, mem_req); end
    step();
    checks++; if (stall !== 1'b0 || pc_load !== 1'b0) begin errors++; $display("FAIL call_resume got stall %0h pc_load %0h exp 0 0", stall, pc_load); end
  endtask

  task automatic test_ret();
    mem_gnt = 1; start_ret = 1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ret_strobe_stall got %0h exp 1", stall); end
    step();
    start_ret = 0;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL ret_pop_req got req %0h we %0h exp 1 0", mem_req, mem_we); end
    checks++; if (mem_addr !== 16'h00FF) begin errors++; $display("FAIL ret_pop_addr got %h exp 00ff", mem_addr); end
    step();
    checks++; if (mem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL ret_wait got req %0h stall %0h exp 0 1", mem_req, stall); end
    checks++; if (sp !== 16'h00FF) begin errors++; $display("FAIL ret_sp got %h exp 00ff", sp); end
    step();
    mem_rvalid = 1; mem_rdata = 32'h104;
    #1;
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL ret_early_load got %0h exp 0", pc_load); end
    step();
    mem_rvalid = 0; mem_rdata = 32'h0;
    checks++; if (pc_load !== 1'b1) begin errors++; $display("FAIL ret_pc_load got %0h exp 1", pc_load); end
    checks++; if (pc_next !== 32'h104) begin errors++; $display("FAIL ret_pc_next got %h exp 104", pc_next); end
    step();
    checks++; if (pc_load !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL ret_resume got pc_load %0h stall %0h exp 0 0", pc_load, stall); end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_gnt = 0; pc_plus4 = 32'h1A0; target = 32'h3C0; start_call = 1;
    step();
    start_call = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_gnt = 1;
      #1;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL bp_req_%0d got req %0h we %0h exp 1 1", i, mem_req, mem_we); end
      checks++; if (mem_addr !== 16'h00FF || mem_wdata !== 32'h1A0) begin errors++; $display("FAIL bp_data_%0d got addr %h wdata %h exp 00ff 1a0", i, mem_addr, mem_wdata); end
      checks++; if (sp !== 16'h00FF) begin errors++; $display("FAIL bp_sp_%0d got %h exp 00ff", i, sp); end
      step();
    end
    checks++; if (sp !== 16'h00FE) begin errors++; $display("FAIL bp_sp_after got %h exp 00fe", sp); end
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'h3C0) begin errors++; $display("FAIL bp_redirect got pc_load %0h pc_next %h exp 1 3c0", pc_load, pc_next); end
    step();
  endtask

  task automatic test_overflow();
    do_reset();
    do_call(32'h10, 32'h20);
    do_call(32'h14, 32'h30);
    do_call(32'h18, 32'h40);
    do_call(32'h1C, 32'h50);
    checks++; if (sp !== 16'h00FB) begin errors++; $display("FAIL ovf_sp_full got %h exp 00fb", sp); end
    start_call = 1; pc_plus4 = 32'h24; target = 32'h60;
    step();
    start_call = 0;
    #1;
    checks++; if (fault !== 2'd1) begin errors++; $display("FAIL ovf_fault got %0d exp 1", fault); end
    checks++; if (mem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL ovf_out got req %0h stall %0h exp 0 1", mem_req, stall); end
    start_ret = 1;
    step();
    start_ret = 0;
    #1;
    checks++; if (state_dbg !== 3'd5 || mem_req !== 1'b0 || sp !== 16'h00FB) begin errors++; $display("FAIL ovf_hold got state %0d req %0h sp %h exp 5 0 00fb", state_dbg, mem_req, sp); end
    fault_clr = 1;
    step();
    fault_clr = 0;
    #1;
    checks++; if (fault !== 2'd0 || state_dbg !== 3'd0) begin errors++; $display("FAIL ovf_clr got fault %0d state %0d exp 0 0", fault, state_dbg); end
    checks++; if (sp !== 16'h00FB || stall !== 1'b0) begin errors++; $display("FAIL ovf_clr_sp got sp %h stall %0h exp 00fb 0", sp, stall); end
  endtask

  task automatic test_underflow_illegal();
    do_reset();
    start_ret = 1;
    step();
    start_ret = 0;
    #1;
    checks++; if (fault !== 2'd2) begin errors++; $display("FAIL unf_fault got %0d exp 2", fault); end
    checks++; if (mem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL unf_out got req %0h stall %0h exp 0 1", mem_req, stall); end
    fault_clr = 1;
    step();
    fault_clr = 0;
    checks++; if (fault !== 2'd0 || state_dbg !== 3'd0) begin errors++; $display("FAIL unf_clr got fault %0d state %0d exp 0 0", fault, state_dbg); end
    start_call = 1; start_ret = 1; pc_plus4 = 32'h88; target = 32'h99;
    step();
    start_call = 0; start_ret = 0;
    #1;
    checks++; if (fault !== 2'd3) begin errors++; $display("FAIL ill_fault got %0d exp 3", fault); end
    checks++; if (mem_req !== 1'b0 || sp !== 16'h00FF) begin errors++; $display("FAIL ill_out got req %0h sp %h exp 0 00ff", mem_req, sp); end
    fault_clr = 1;
    step();
    fault_clr = 0;
    checks++; if (fault !== 2'd0 || stall !== 1'b0) begin errors++; $display("FAIL ill_clr got fault %0d stall %0h exp 0 0", fault, stall); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    // Reset while a PUSH waits for its grant.
    mem_gnt = 0; pc_plus4 = 32'h70; target = 32'h700; start_call = 1;
    step();
    start_call = 0;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_push_req got %0h exp 1", mem_req); end
    #2;
    rst = 1;
    #1;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rmid_push_drop got req %0h stall %0h exp 0 0", mem_req, stall); end
    #1;
    rst = 0;
    step();
    // Reset while POP_WAIT waits for read data.
    do_call(32'h55C, 32'h600);
    start_ret = 1;
    step();
    start_ret = 0;
    step();
    checks++; if (state_dbg !== 3'd3 || sp !== 16'h00FF) begin errors++; $display("FAIL rmid_popwait got state %0d sp %h exp 3 00ff", state_dbg, sp); end
    #2;
    rst = 1;
    #1;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || sp !== 16'h00FF || state_dbg !== 3'd0) begin errors++; $display("FAIL rmid_pop_drop got req %0h stall %0h sp %h state %0d exp 0 0 00ff 0", mem_req, stall, sp, state_dbg); end
    #1;
    rst = 0;
    step();
    mem_rvalid = 1; mem_rdata = 32'hDEAD;
    step();
    mem_rvalid = 0;
    #1;
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL rmid_late_rvalid got pc_load %0h exp 0", pc_load); end
    step();
    checks++; if (pc_load !== 1'b0 || pc_next !== 32'h0 || state_dbg !== 3'd0) begin errors++; $display("FAIL rmid_after got pc_load %0h pc_next %h state %0d exp 0 0 0", pc_load, pc_next, state_dbg); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_call();
    test_ret();
    test_backpressure();
    test_overflow();
    test_underflow_illegal();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_call_ret_seq
